gf2m_digit_mult: RTL

Parametrised digit-serial LSB-first multiplier over GF(2^M) with a configurable reduction polynomial. It processes D bits of the multiplier operand per clock and offers a start/ready/done handshake. It is the next-generation field multiplier for the ECC point-arithmetic datapath: a drop-in successor to the fixed 163-bit bit-serial multiplier, with selectable throughput per area.

---
 rtl/gf2m_pkg.sv | 27 ++
 rtl/gf2m_digit_step.sv | 38 +++
 rtl/gf2m_digit_mult.sv | 101 ++++++++++
 3 files changed

// File: rtl/gf2m_pkg.sv
// gf2m_pkg: constants and types shared by the GF(2^m) digit-serial multiplier.
//   DEF_M      default field degree
//   B163_POLY  low-order terms of x^163 + x^7 + x^6 + x^3 + 1 (used by B-163 and K-163)
//   K163_POLY  same pentanomial as B163_POLY
//   B233_POLY  low-order terms of x^233 + x^74 + 1
//   state_e    multiplier FSM states (2-bit encoding)
//   ceil_div   integer ceiling division, used to derive the digit count
package gf2m_pkg;

  localparam int DEF_M = 163;
  localparam int DEF_D = 1;

  localparam logic [162:0] B163_POLY = 163'hC9;
  localparam logic [162:0] K163_POLY = 163'hC9;
  localparam logic [232:0] B233_POLY = (233'd1 << 74) | 233'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/gf2m_digit_step.sv
// gf2m_digit_step: one clock's worth of LSB-first multiply work.
// Processes D multiplier bits as a chain of D shift-reduce/accumulate stages.
//   a      current multiplicand A (already scaled by x^(D*k))
//   b_dig  the D multiplier bits consumed this cycle, bit 0 first
//   c      accumulator in
//   a_next A * x^D mod f
//   c_next c xor sum over j of b_dig[j] * A * x^j mod f
module gf2m_digit_step
  import gf2m_pkg::*;
#(
  parameter int           M    = DEF_M,
  parameter logic [M-1:0] POLY = M'(B163_POLY),
  parameter int           D    = DEF_D
)(
  input  logic [M-1:0] a,
  input  logic [D-1:0] b_dig,
  input  logic [M-1:0] c,
  output logic [M-1:0] a_next,
  output logic [M-1:0] c_next
);

  logic [D:0][M-1:0] a_ch;
  logic [D:0][M-1:0] c_ch;

  assign a_ch[0] = a;
  assign c_ch[0] = c;

  for (genvar j = 0; j < D; j++) begin : g_stage
    // Accumulate before scaling, so bit j multiplies A*x^j.
    assign c_ch[j+1] = c_ch[j] ^ (b_dig[j] ? a_ch[j] : '0);
    // Multiply by x: the bit shifted out at x^M folds back as POLY.
    assign a_ch[j+1] = {a_ch[j][M-2:0], 1'b0} ^ (a_ch[j][M-1] ? POLY : '0);
  end

  assign a_next = a_ch[D];
  assign c_next = c_ch[D];

endmodule

// File: rtl/gf2m_digit_mult.sv
// gf2m_digit_mult: digit-serial LSB-first multiplier over GF(2^M), f = x^M + POLY.
// Consumes D bits of b per clock; result after N = ceil(M/D) RUN cycles.
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start        request, accepted when ready=1
//   a, b         operands, sampled on the accepting edge
//   ready        high in IDLE and DONE
//   busy         high in RUN
//   done         one-cycle pulse, z valid
//   z            product a*b mod f, held until the next accepted start
// Optional build macro GF2M_MULT_EARLY_EXIT_EN: finish as soon as the remaining
// multiplier bits are all zero (data-dependent latency). Leave it undefined for
// constant-time operation.
module gf2m_digit_mult
  import gf2m_pkg::*;
#(
  parameter int           M    = DEF_M,
  parameter logic [M-1:0] POLY = M'(B163_POLY),
  parameter int           D    = DEF_D
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] z
);

  localparam int N  = ceil_div(M, D);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_e        state, state_nxt;
  logic [M-1:0]  ra, rb, rc;
  logic [M-1:0]  a_step, c_step, rb_nxt;
  logic [CW-1:0] cnt;
  logic          accept, last;

  // Zero fill: digits past bit M-1 of the final partial digit read as zero.
  assign rb_nxt = rb >> D;
  assign accept = ready & start;

`ifdef GF2M_MULT_EARLY_EXIT_EN
  assign last = (cnt == CW'(N - 1)) || (rb_nxt == '0);
`else
  assign last = (cnt == CW'(N - 1));
`endif

  gf2m_digit_step #(.M(M), .POLY(POLY), .D(D)) u_step (
    .a      (ra),
    .b_dig  (rb[D-1:0]),
    .c      (rc),
    .a_next (a_step),
    .c_next (c_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE: state_nxt = start ? ST_RUN : ST_IDLE;
      ST_RUN:  state_nxt = last  ? ST_DONE : ST_RUN;
      ST_DONE: state_nxt = start ? ST_RUN : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs depend on state only; no combinational path from start.
  always_comb begin
    ready = (state == ST_IDLE) || (state == ST_DONE);
    busy  = (state == ST_RUN);
    done  = (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra  <= '0;
      rb  <= '0;
      rc  <= '0;
      cnt <= '0;
    end else if (accept) begin
      ra  <= a;
      rb  <= b;
      rc  <= '0;
      cnt <= '0;
    end else if (state == ST_RUN) begin
      ra  <= a_step;
      rb  <= rb_nxt;
      rc  <= c_step;
      cnt <= cnt + CW'(1);
    end
  end

  assign z = rc;

endmodule
